ro_capture_ctrl: RTL

- Sequences the two-ring-oscillator entropy buffer: enables both ROs, waits for warm-up and shift-register flush, then harvests fresh 8-bit random bytes from the buffer's byte output.
- Delivers bytes to a consumer over a valid/ready handshake.
- Supports one-shot (NUM_BYTES bytes) and continuous harvesting, plus abort.

---
 rtl/ro_capture_ctrl_pkg.sv | 28 ++
 rtl/ro_capture_ctrl_byte_hold.sv | 58 +++++
 rtl/ro_capture_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ro_capture_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator capture controller.
package ro_ctrl_pkg;

   // Controller states, in the order a one-shot run visits them.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WARMUP  = 3'd1,
      FILL    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } ctrl_state_e;

   // The buffer byte-select is pinned to the least-significant byte.
   localparam logic [2:0] OUT_SEL_LSB = 3'b000;

   // Harvests are spaced a full byte apart so consecutive bytes share no shift bits.
   localparam int BYTE_SPACING = 8;
   localparam int PHASE_W      = 3;

   // Bits needed for a counter that must hold values up to maxVal.
   function automatic int cntWidth(input int maxVal);
      if (maxVal < 2) begin
         return 1;
      end
      return $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/ro_capture_ctrl_byte_hold.sv
// Single-entry valid/ready holding register. A harvest that arrives while the
// previous byte is still unconsumed is dropped and flagged as overflow.
module ro_byte_hold
   import ro_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       harvest_i,
   input  logic       clear_ovf_i,
   input  logic [7:0] data_i,
   input  logic       ready_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       overflow_o
);

   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       ovf_q, ovf_d;

   // Decide what the holding register looks like after this edge: load, keep, drain or drop.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      if (clear_ovf_i) begin
         ovf_d = 1'b0;
      end
      if (harvest_i) begin
         if (!valid_q || ready_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Register the holding entry; reset discards any byte still waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/ro_capture_ctrl.sv
// Sequencer for the two-ring-oscillator entropy buffer: warm up the ROs, flush
// stale shift bits, then harvest one fresh byte every BYTE_SPACING cycles.
module ro_capture_ctrl
   import ro_ctrl_pkg::*;
#(
   parameter int WARMUP_CYCLES = 16,
   parameter int FILL_CYCLES   = 10,
   parameter int NUM_BYTES     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       continuous,
   input  logic       stop,
   output logic       ro_activate_1,
   output logic       ro_activate_2,
   output logic [2:0] out_sel,
   input  logic [7:0] rng_byte,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       busy,
   output logic       done,
   output logic       overflow
);

   localparam int CYC_MAX = (WARMUP_CYCLES > FILL_CYCLES) ? WARMUP_CYCLES : FILL_CYCLES;
   localparam int CYC_W   = cntWidth(CYC_MAX);
   localparam int BYTE_W  = cntWidth(NUM_BYTES);

   localparam logic [CYC_W-1:0]   WARM_LAST  = CYC_W'(WARMUP_CYCLES - 1);
   localparam logic [CYC_W-1:0]   FILL_LAST  = CYC_W'(FILL_CYCLES - 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BYTE_SPACING - 1);
   localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(NUM_BYTES - 1);

   ctrl_state_e        state_q, state_d;
   logic [CYC_W-1:0]   cycCnt_q, cycCnt_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [BYTE_W-1:0]  byteCnt_q, byteCnt_d;
   logic               cont_q, cont_d;

   logic startAccept;
   logic harvest;
   logic lastByte;

   // A start only counts from IDLE, and a simultaneous stop suppresses it.
   assign startAccept = (state_q == IDLE) && start && !stop;

   // Harvest at the end of each byte window; an abort on the same edge wins.
   assign harvest = (state_q == CAPTURE) && (phase_q == PHASE_LAST) && !stop;

   // The final one-shot harvest ends the run instead of continuing capture.
   assign lastByte = harvest && !cont_q && (byteCnt_q == BYTE_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: abort from any active state, otherwise step through the timed phases.
   always_comb begin
      state_d = state_q;
      if (state_q != IDLE && stop) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (startAccept) begin
                  state_d = WARMUP;
               end
            end
            WARMUP: begin
               if (cycCnt_q == WARM_LAST) begin
                  state_d = FILL;
               end
            end
            FILL: begin
               if (cycCnt_q == FILL_LAST) begin
                  state_d = CAPTURE;
               end
            end
            CAPTURE: begin
               if (lastByte) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Output logic: ROs run through warm-up, fill and capture; done marks the single DONE cycle.
   always_comb begin
      ro_activate_1 = 1'b0;
      ro_activate_2 = 1'b0;
      busy          = (state_q != IDLE);
      done          = (state_q == DONE);
      out_sel       = OUT_SEL_LSB;
      if (state_q == WARMUP || state_q == FILL || state_q == CAPTURE) begin
         ro_activate_1 = 1'b1;
         ro_activate_2 = 1'b1;
      end
   end

   // Counter next values: the cycle counter times warm-up and fill, phase and byte count pace capture.
   always_comb begin
      cycCnt_d  = '0;
      phase_d   = '0;
      byteCnt_d = byteCnt_q;
      cont_d    = cont_q;
      case (state_q)
         IDLE: begin
            byteCnt_d = '0;
            if (startAccept) begin
               cont_d = continuous;
            end
         end
         WARMUP: begin
            if (cycCnt_q != WARM_LAST) begin
               cycCnt_d = cycCnt_q + 1'b1;
            end
         end
         FILL: begin
            if (cycCnt_q != FILL_LAST) begin
               cycCnt_d = cycCnt_q + 1'b1;
            end
         end
         CAPTURE: begin
            phase_d = phase_q + 1'b1;
            if (harvest) begin
               byteCnt_d = byteCnt_q + 1'b1;
            end
         end
         default: begin
            byteCnt_d = '0;
         end
      endcase
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycCnt_q  <= '0;
         phase_q   <= '0;
         byteCnt_q <= '0;
         cont_q    <= 1'b0;
      end else begin
         cycCnt_q  <= cycCnt_d;
         phase_q   <= phase_d;
         byteCnt_q <= byteCnt_d;
         cont_q    <= cont_d;
      end
   end

   ro_byte_hold uHold (
      .clk         (clk),
      .rst_n       (rst_n),
      .harvest_i   (harvest),
      .clear_ovf_i (startAccept),
      .data_i      (rng_byte),
      .ready_i     (byte_ready),
      .data_o      (byte_data),
      .valid_o     (byte_valid),
      .overflow_o  (overflow)
   );

endmodule
